// File: rtl/psc_tx_scheduler.sv
// Shares the PSC serial frame path between trigger, status and host command packets.
// Arbitration happens only at packet boundaries, and one byte is emitted per frame slot.
module psc_tx_scheduler #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         MAX_BURST  = 4,
  parameter logic [7:0] IDLE_BYTE  = 8'h00,
  parameter logic [7:0] TRIG_BYTE  = 8'hA5,
  parameter logic [7:0] STAT_HDR   = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot,
  input  logic       trig_req,
  input  logic       stat_req,
  input  logic [7:0] stat_data,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] tx_byte,
  output logic [3:0] tx_counter,
  output logic       tx_active,
  output logic       trig_ack,
  output logic       trig_missed
);

  // state      | meaning
  // S_IDLE     | no packet, IDLE_BYTE on the line
  // S_TRIG     | sending the one-byte trigger packet
  // S_STAT_HDR | sending the status header
  // S_STAT_DAT | sending the frozen status byte
  // S_CMD_HDR  | sending {4'hC, n}
  // S_CMD_DAT  | sending command byte tx_counter of n
  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_STAT_HDR, S_STAT_DAT, S_CMD_HDR, S_CMD_DAT
  } state_t;

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]      BURST_C = 8'(MAX_BURST);

  state_t        state;
  logic [3:0]    burst_n;
  logic          trig_pending;
  logic          stat_pending;
  logic [7:0]    stat_buf;
  logic [7:0]    stat_frozen;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          push;
  logic          pop;
  logic          at_last;
  logic          decide;
  logic          trig_sel;
  logic          stat_sel;
  logic          cmd_sel;
  logic [7:0]    cnt_ext;
  logic [3:0]    hdr_n;

  always_comb begin
    cnt_ext  = 8'(count);
    hdr_n    = (cnt_ext >= BURST_C) ? BURST_C[3:0] : cnt_ext[3:0];
    at_last  = (state == S_IDLE) || (state == S_TRIG) || (state == S_STAT_DAT) ||
               ((state == S_CMD_DAT) && (tx_counter == burst_n));
    decide   = slot && at_last;
    trig_sel = decide && (trig_pending || trig_req);
    stat_sel = decide && !trig_sel && (stat_pending || stat_req);
    cmd_sel  = decide && !trig_sel && !stat_sel && (count != '0);
    push     = cmd_valid && cmd_ready;
    // n was frozen at the header, so the FIFO holds at least n bytes here
    pop      = slot && ((state == S_CMD_HDR) ||
                        ((state == S_CMD_DAT) && (tx_counter != burst_n)));
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      cmd_ready <= (count_next < DEPTH_C);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      tx_byte      <= IDLE_BYTE;
      tx_counter   <= 4'd0;
      tx_active    <= 1'b0;
      burst_n      <= 4'd0;
      trig_pending <= 1'b0;
      stat_pending <= 1'b0;
      stat_buf     <= 8'h00;
      stat_frozen  <= 8'h00;
      trig_ack     <= 1'b0;
      trig_missed  <= 1'b0;
    end else begin
      trig_ack    <= trig_sel;
      trig_missed <= trig_req && trig_pending;

      if (trig_sel)      trig_pending <= 1'b0;
      else if (trig_req) trig_pending <= 1'b1;

      if (stat_req) stat_buf <= stat_data;
      // a request on the entry edge itself supplies the byte directly
      if (stat_sel) begin
        stat_pending <= 1'b0;
        stat_frozen  <= stat_req ? stat_data : stat_buf;
      end else if (stat_req) begin
        stat_pending <= 1'b1;
      end

      if (slot) begin
        if (decide) begin
          tx_counter <= 4'd0;
          if (trig_sel) begin
            state     <= S_TRIG;
            tx_byte   <= TRIG_BYTE;
            tx_active <= 1'b1;
          end else if (stat_sel) begin
            state     <= S_STAT_HDR;
            tx_byte   <= STAT_HDR;
            tx_active <= 1'b1;
          end else if (cmd_sel) begin
            state     <= S_CMD_HDR;
            tx_byte   <= {4'hC, hdr_n};
            tx_active <= 1'b1;
            burst_n   <= hdr_n;
          end else begin
            state     <= S_IDLE;
            tx_byte   <= IDLE_BYTE;
            tx_active <= 1'b0;
          end
        end else begin
          tx_counter <= tx_counter + 4'd1;
          case (state)
            S_STAT_HDR: begin
              state   <= S_STAT_DAT;
              tx_byte <= stat_frozen;
            end
            default: begin
              state   <= S_CMD_DAT;
              tx_byte <= mem[rd_ptr];
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_psc_tx_scheduler.sv
// Scenario bench for psc_tx_scheduler: expected packet bytes are queued as stimulus is
// driven, and a slot monitor pops and compares them against tx_byte/tx_counter.
module tb_psc_tx_scheduler;

  localparam logic [7:0] IDLE_B = 8'h00;

  logic       clk;
  logic       reset;
  logic       slot;
  logic       trig_req;
  logic       stat_req;
  logic [7:0] stat_data;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_byte;
  logic [3:0] tx_counter;
  logic       tx_active;
  logic       trig_ack;
  logic       trig_missed;

  typedef struct {
    logic [7:0] b;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  psc_tx_scheduler dut (
    .clk(clk), .reset(reset), .slot(slot), .trig_req(trig_req),
    .stat_req(stat_req), .stat_data(stat_data), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .tx_byte(tx_byte),
    .tx_counter(tx_counter), .tx_active(tx_active), .trig_ack(trig_ack),
    .trig_missed(trig_missed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slot monitor: every slot edge yields either the next queued packet byte or idle.
  always begin
    @(posedge clk);
    if (slot && reset) begin
      #1;
      n_vec++;
      if (tx_active) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %h idx %0d, required idle", tx_byte, tx_counter);
        end else begin
          mon_e = exp_q.pop_front();
          if (tx_byte !== mon_e.b || tx_counter !== mon_e.c) begin
            n_err++;
            $display("FAIL packet_byte: got %h idx %0d, required %h idx %0d",
                     tx_byte, tx_counter, mon_e.b, mon_e.c);
          end
        end
      end else if (tx_byte !== IDLE_B || tx_counter !== 4'd0) begin
        n_err++;
        $display("FAIL idle_slot: got %h idx %0d, required %h idx 0", tx_byte, tx_counter, IDLE_B);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_byte(input logic [7:0] b, input logic [3:0] c);
    exp_t e;
    e.b = b;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic slot_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) slot = 1'b1;
      @(negedge clk) slot = 1'b0;
    end
  endtask

  task automatic push_cmd(input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_trig();
    @(negedge clk) trig_req = 1'b1;
    @(negedge clk) trig_req = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d expected bytes never sent, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (tx_byte !== IDLE_B || tx_counter !== 4'd0 || tx_active !== 1'b0 ||
        trig_ack !== 1'b0 || trig_missed !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got byte %h idx %0d act %b ack %b miss %b rdy %b, required 00 0 0 0 0 0",
               tx_byte, tx_counter, tx_active, trig_ack, trig_missed, cmd_ready);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge: got %b, required 0", cmd_ready);
    end
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_edge: got %b, required 1", cmd_ready);
    end
    slot_pulse(3);
    check_drained("reset");
  endtask

  task automatic test_trigger();
    expect_byte(8'hA5, 4'd0);
    @(negedge clk);
    slot     = 1'b1;
    trig_req = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (trig_ack !== 1'b1) begin
      n_err++;
      $display("FAIL trig_ack_rise: got %b, required 1", trig_ack);
    end
    @(negedge clk);
    slot     = 1'b0;
    trig_req = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (trig_ack !== 1'b0 || tx_byte !== 8'hA5) begin
      n_err++;
      $display("FAIL trig_ack_fall: got ack %b byte %h, required ack 0 byte a5", trig_ack, tx_byte);
    end
    slot_pulse(2);
    check_drained("trigger");
  endtask

  task automatic test_cmd_burst();
    for (int i = 0; i < 6; i++) push_cmd(8'h11 + 8'(i));
    expect_byte(8'hC4, 4'd0);
    for (int i = 0; i < 4; i++) expect_byte(8'h11 + 8'(i), 4'(i + 1));
    expect_byte(8'hC2, 4'd0);
    expect_byte(8'h15, 4'd1);
    expect_byte(8'h16, 4'd2);
    slot_pulse(9);
    check_drained("cmd_burst");
  endtask

  task automatic test_priority();
    @(negedge clk);
    stat_req  = 1'b1;
    stat_data = 8'h3C;
    @(negedge clk);
    stat_req  = 1'b0;
    stat_data = 8'hFF;
    pulse_trig();
    push_cmd(8'h77);
    expect_byte(8'hA5, 4'd0);
    expect_byte(8'h5A, 4'd0);
    expect_byte(8'h3C, 4'd1);
    expect_byte(8'hC1, 4'd0);
    expect_byte(8'h77, 4'd1);
    slot_pulse(6);
    check_drained("priority");
  endtask

  task automatic test_trig_missed();
    for (int i = 0; i < 4; i++) push_cmd(8'h21 + 8'(i));
    expect_byte(8'hC4, 4'd0);
    for (int i = 0; i < 4; i++) expect_byte(8'h21 + 8'(i), 4'(i + 1));
    expect_byte(8'hA5, 4'd0);
    slot_pulse(1);
    pulse_trig();
    n_vec++;
    if (trig_missed !== 1'b0) begin
      n_err++;
      $display("FAIL first_trig_missed: got %b, required 0", trig_missed);
    end
    slot_pulse(1);
    @(negedge clk) trig_req = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (trig_missed !== 1'b1) begin
      n_err++;
      $display("FAIL second_trig_missed: got %b, required 1", trig_missed);
    end
    @(negedge clk) trig_req = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (trig_missed !== 1'b0) begin
      n_err++;
      $display("FAIL trig_missed_width: got %b, required 0", trig_missed);
    end
    slot_pulse(6);
    check_drained("trig_missed");
  endtask

  task automatic test_full_and_reset();
    for (int i = 0; i < 8; i++) push_cmd(8'h31 + 8'(i));
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: got %b, required 0", cmd_ready);
    end
    push_cmd(8'h39);
    expect_byte(8'hC4, 4'd0);
    for (int i = 0; i < 4; i++) expect_byte(8'h31 + 8'(i), 4'(i + 1));
    expect_byte(8'hC4, 4'd0);
    for (int i = 0; i < 4; i++) expect_byte(8'h35 + 8'(i), 4'(i + 1));
    slot_pulse(11);
    check_drained("fifo_full");
    for (int i = 0; i < 3; i++) push_cmd(8'h41 + 8'(i));
    expect_byte(8'hC3, 4'd0);
    expect_byte(8'h41, 4'd1);
    slot_pulse(2);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (tx_byte !== IDLE_B || tx_counter !== 4'd0 || tx_active !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got byte %h idx %0d act %b rdy %b, required 00 0 0 0",
               tx_byte, tx_counter, tx_active, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b, required 1", cmd_ready);
    end
    slot_pulse(3);
    check_drained("mid_reset");
  endtask

  initial begin
    reset     = 1'b0;
    slot      = 1'b0;
    trig_req  = 1'b0;
    stat_req  = 1'b0;
    stat_data = 8'h00;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    test_reset();
    test_trigger();
    test_cmd_burst();
    test_priority();
    test_trig_missed();
    test_full_and_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psc_tx_scheduler.md
# psc_tx_scheduler

Packet scheduler that shares the single PSC serial frame path between three requesters: EVR trigger, status report and host command bytes. It arbitrates at packet boundaries and emits one byte per frame slot, plus the in-packet byte index, to the frame encoder and shift-register chain. It sits between the trigger detector/host interface and the frame encoder, in the frame-clock domain, and replaces direct byte driving by the trigger FSM.

## Interface
- FIFO_DEPTH, 8: command FIFO depth; power of two, 2..64.
- MAX_BURST, 4: maximum command data bytes per packet; 1..15.
- IDLE_BYTE, 8'h00: byte sent when no packet is active.
- TRIG_BYTE, 8'hA5: single-byte trigger packet.
- STAT_HDR, 8'h5A: status packet header.

- clk  in  1  frame-domain clock; one clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- slot  in  1  one-cycle pulse marking the start of a frame slot.
- trig_req  in  1  one-cycle trigger request pulse.
- stat_req  in  1  one-cycle status request pulse.
- stat_data  in  8  status byte, sampled when stat_req=1.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  command byte offered.
- cmd_ready  out  1  FIFO not full; a write occurs when cmd_valid and cmd_ready are both 1.
- tx_byte  out  8  byte for the current slot, to the frame encoder.
- tx_counter  out  4  byte index within the current packet (0 = first byte).
- tx_active  out  1  a packet byte is being sent in the current slot.
- trig_ack  out  1  pulse: trigger byte issued.
- trig_missed  out  1  pulse: trigger request arrived while a trigger was already pending.

## Operation
- Packets:
  - TRIGGER: TRIG_BYTE, 1 byte.
  - STATUS: STAT_HDR, then the captured stat_data; 2 bytes.
  - COMMAND: header {4'hC, n[3:0]}, then n FIFO bytes, where n = min(FIFO count, MAX_BURST) and n is frozen at the header decision.
- States: IDLE, TRIG, STAT_HDR, STAT_DAT, CMD_HDR, CMD_DAT. The FSM advances only on clk edges with slot=1.
- Decision point: at a slot edge in IDLE, or at the slot edge after a packet's last byte. Priority at the decision point:
  1. TRIG if trig_pending or trig_req.
  2. STAT_HDR if stat_pending or stat_req.
  3. CMD_HDR if the FIFO count ≥ 1.
  4. Otherwise IDLE.
- Arbitration is non-preemptive. A packet in progress always completes.
- trig_pending:
  - Set by trig_req when it is not consumed on the same edge.
  - Cleared when TRIG is entered.
  - If trig_req=1 while trig_pending=1, trig_missed pulses and trig_pending stays 1.
- stat_pending:
  - Set by stat_req, which also recaptures stat_data; the last request before STAT_HDR wins.
  - Cleared when STAT_HDR is entered.
  - The data byte is frozen at STAT_HDR entry.
- FIFO:
  - Pops once per CMD_DAT slot.
  - A write and a pop in the same cycle are both honoured.
  - cmd_ready = (count < FIFO_DEPTH), registered so it reflects the post-edge count.
- Outputs:
  - IDLE: tx_byte=IDLE_BYTE, tx_counter=0, tx_active=0.
  - Within a packet, tx_counter increments by 1 per slot starting from 0.
  - The maximum index is MAX_BURST, so it never wraps.
- trig_ack pulses for exactly one cycle, on the edge that enters TRIG.

## Timing
- All outputs are registered. tx_byte, tx_counter and tx_active change only on slot edges and hold until the next slot edge.
- Latency from a decision edge to the new byte on tx_byte: 1 clk.
- A trig_req coincident with slot in IDLE is issued on that same edge.
- Worst-case trigger latency = (1 + MAX_BURST) slots plus the remainder of the current slot.
- Reset values: tx_byte=IDLE_BYTE, tx_counter=0, tx_active=0, trig_ack=0, trig_missed=0, cmd_ready=0, pending flags 0, FIFO empty.
- cmd_ready rises on the first edge after reset deasserts.
- Reset mid-packet aborts the packet immediately (asynchronous). There is no resume and no partial replay.
- slot may be asserted on consecutive cycles; each assertion is one slot.

## Test plan
- Reset, then 3 idle slots -> tx_byte=8'h00, tx_active=0, cmd_ready=1 after the first post-reset edge.
- trig_req together with slot in IDLE -> next cycle tx_byte=8'hA5, tx_counter=0, trig_ack=1 for 1 cycle; the following slot returns to IDLE.
- Push 6 bytes 8'h11..8'h16, then slots -> packet 8'hC4, 11, 12, 13, 14, then packet 8'hC2, 15, 16; tx_counter 0..4, then 0..2.
- stat_req with stat_data=8'h3C, trig_req and cmd push all before one IDLE slot -> order A5, then 5A, 3C, then the C-packet.
- trig_req during a C4 packet, then a second trig_req -> trig_missed=1 once; exactly one A5 is sent, on the slot after the packet's last byte.
- Fill the FIFO to 8 -> cmd_ready=0 and the 9th cmd_valid is not written. Assert reset mid CMD_DAT -> outputs return to reset values asynchronously, the FIFO is empty, and no header follows.
